// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor.
//
// The WIDTH-bit operation is split into NBLK = WIDTH/BLOCK blocks. Stage k resolves
// block k and registers it, so one operation is accepted per cycle and the latency is
// NBLK edges from capture into stage 0. A single global stall freezes every stage
// while the output is held by the consumer.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   operation presented          in_ready   stage can accept
//   a, b       operands                     sub        1 = a - b, 0 = a + b
//   cin        carry-in (add) / borrow-in (sub)
//   out_valid  result present               out_ready  consumer accepts
//   sum        result                       cout       raw carry out of bit WIDTH-1
//   ovf        signed two's-complement overflow
module csa_pipe_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLOCK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NBLK = WIDTH / BLOCK;

   // Per-stage state. res_q[k] holds result slices 0..k; opa_q/opb_q hold the operand
   // bits not yet consumed, shifted down so the next block always sits at [BLOCK-1:0].
   logic [NBLK-1:0]  valid_q, valid_d;
   logic [NBLK-1:0]  carry_q, carry_d;
   logic [WIDTH-1:0] res_q [NBLK];
   logic [WIDTH-1:0] res_d [NBLK];
   logic [WIDTH-1:0] opa_q [NBLK];
   logic [WIDTH-1:0] opa_d [NBLK];
   logic [WIDTH-1:0] opb_q [NBLK];
   logic [WIDTH-1:0] opb_d [NBLK];
   logic             ovf_q, ovf_d;

   logic             stall;
   logic             accept;

   // Working values for the stage currently being evaluated in the loop below.
   logic [WIDTH-1:0] a_cur, b_cur, r_cur;
   logic             c_cur, v_cur;
   logic [BLOCK-1:0] s0, s1, s_sel;
   logic             co0, co1, co_sel;

   assign stall    = valid_q[NBLK-1] && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && !stall;

   always_comb begin
      // Stage 0 is fed straight from the inputs with the subtract folded in.
      a_cur   = a;
      b_cur   = sub ? ~b : b;
      c_cur   = cin ^ sub;
      v_cur   = accept;
      r_cur   = '0;
      s0      = '0;
      s1      = '0;
      s_sel   = '0;
      co0     = 1'b0;
      co1     = 1'b0;
      co_sel  = 1'b0;
      ovf_d   = 1'b0;
      valid_d = '0;
      carry_d = '0;
      for (int k = 0; k < NBLK; k++) begin
         res_d[k] = '0;
         opa_d[k] = '0;
         opb_d[k] = '0;
      end

      for (int k = 0; k < NBLK; k++) begin
         // Both candidate sums are formed, then the incoming carry picks one.
         {co0, s0} = {1'b0, a_cur[BLOCK-1:0]} + {1'b0, b_cur[BLOCK-1:0]};
         {co1, s1} = {1'b0, a_cur[BLOCK-1:0]} + {1'b0, b_cur[BLOCK-1:0]}
                     + {{BLOCK{1'b0}}, 1'b1};
         s_sel  = c_cur ? s1 : s0;
         co_sel = c_cur ? co1 : co0;

         valid_d[k] = v_cur;
         carry_d[k] = co_sel;
         res_d[k]   = r_cur | (WIDTH'(s_sel) << (k * BLOCK));
         opa_d[k]   = a_cur >> BLOCK;
         opb_d[k]   = b_cur >> BLOCK;

         // Carry into the block MSB is recovered from its sum bit; only the top
         // block's value survives the loop.
         ovf_d = a_cur[BLOCK-1] ^ b_cur[BLOCK-1] ^ s_sel[BLOCK-1] ^ co_sel;

         // The next stage works from this stage's registered state.
         a_cur = opa_q[k];
         b_cur = opb_q[k];
         c_cur = carry_q[k];
         v_cur = valid_q[k];
         r_cur = res_q[k];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < NBLK; k++) begin
            res_q[k] <= '0;
            opa_q[k] <= '0;
            opb_q[k] <= '0;
         end
      end else if (!stall) begin
         valid_q <= valid_d;
         // Bubbles leave the data registers untouched.
         for (int k = 0; k < NBLK; k++) begin
            if (valid_d[k]) begin
               res_q[k]   <= res_d[k];
               carry_q[k] <= carry_d[k];
               opa_q[k]   <= opa_d[k];
               opb_q[k]   <= opb_d[k];
            end
         end
         if (valid_d[NBLK-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign out_valid = valid_q[NBLK-1];
   assign sum       = res_q[NBLK-1];
   assign cout      = carry_q[NBLK-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed bench for csa_pipe_adder: three instances (32/8, 16/4, 8/8) sharing a clock
// and reset. Inputs are driven and outputs sampled on the falling edge.
module tb_csa_pipe_adder;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // 32-bit, 4-block instance
   logic        in_valid32, in_ready32, sub32, cin32, out_valid32, out_ready32;
   logic        cout32, ovf32;
   logic [31:0] a32, b32, sum32;

   // 16-bit, 4-block instance
   logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16;
   logic        cout16, ovf16;
   logic [15:0] a16, b16, sum16;

   // 8-bit, single-block instance
   logic        in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8;
   logic        cout8, ovf8;
   logic [7:0]  a8, b8, sum8;

   csa_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
      .clock(clk), .reset(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .sub(sub32), .cin(cin32), .out_valid(out_valid32),
      .out_ready(out_ready32), .sum(sum32), .cout(cout32), .ovf(ovf32)
   );

   csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
      .clock(clk), .reset(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .sub(sub16), .cin(cin16), .out_valid(out_valid16),
      .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   csa_pipe_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
      .clock(clk), .reset(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .sub(sub8), .cin(cin8), .out_valid(out_valid8),
      .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One operation on the 32-bit instance with out_ready=1: out_valid must stay low
   // after the accept edge and the next two, rise after the third, and drop again.
   task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tsub, input logic tcin, input logic [31:0] es,
                        input logic ec, input logic eo);
      @(negedge clk);
      a32 = ta; b32 = tb; sub32 = tsub; cin32 = tcin; in_valid32 = 1'b1;
      #1 check({tag, ":in_ready"}, 64'(in_ready32), 64'(1));
      @(negedge clk);
      in_valid32 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         if (i < 3) begin
            check({tag, ":early"}, 64'(out_valid32), 64'(0));
         end else begin
            check({tag, ":valid"}, 64'(out_valid32), 64'(1));
            check({tag, ":sum"}, 64'(sum32), 64'(es));
            check({tag, ":cout"}, 64'(cout32), 64'(ec));
            check({tag, ":ovf"}, 64'(ovf32), 64'(eo));
         end
      end
      @(negedge clk);
      check({tag, ":retired"}, 64'(out_valid32), 64'(0));
   endtask

   logic [31:0] sa [6];
   logic [31:0] sb [6];
   logic        ss [6];
   logic [31:0] se [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int sent, got, stall_left;
      bit stalled;

      sa = '{32'h1, 32'h10, 32'h100, 32'hFFFF, 32'h12345678, 32'h0};
      sb = '{32'h2, 32'h20, 32'h1, 32'h1, 32'h11111111, 32'h1};
      ss = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      se = '{32'h3, 32'h30, 32'hFF, 32'h10000, 32'h23456789, 32'hFFFFFFFF};

      rst_n = 1'b0;
      in_valid32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; cin32 = 1'b0; out_ready32 = 1'b1;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; cin16 = 1'b0; out_ready16 = 1'b1;
      in_valid8  = 1'b0; a8  = '0; b8  = '0; sub8  = 1'b0; cin8  = 1'b0; out_ready8  = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst:out_valid", 64'(out_valid32), 64'(0));
      check("rst:in_ready", 64'(in_ready32), 64'(1));
      check("rst:sum", 64'(sum32), 64'(0));
      check("rst:cout", 64'(cout32), 64'(0));
      rst_n = 1'b1;

      // Single operations
      run32("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      run32("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
      run32("add_cin", 32'h3, 32'h4, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
      run32("sub_neg", 32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
      run32("sub_ovf", 32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
      run32("sub_borrow", 32'h80000000, 32'h1, 1'b1, 1'b1, 32'h7FFFFFFE, 1'b1, 1'b1);

      // Six back-to-back operations with a three-cycle stall on the first result
      sent = 0; got = 0; stall_left = 0; stalled = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clk);
         if (!stalled && out_valid32) begin
            stalled    = 1'b1;
            stall_left = 3;
         end
         out_ready32 = (stall_left == 0);
         in_valid32  = (sent < 6);
         if (sent < 6) begin
            a32 = sa[sent]; b32 = sb[sent]; sub32 = ss[sent]; cin32 = 1'b0;
         end
         #1;
         if (stall_left > 0) begin
            check("stall:in_ready", 64'(in_ready32), 64'(0));
            check("stall:out_valid", 64'(out_valid32), 64'(1));
            check("stall:sum_held", 64'(sum32), 64'(se[0]));
            stall_left--;
         end
         if (out_valid32 && out_ready32) begin
            check($sformatf("stream:sum%0d", got), 64'(sum32), 64'(se[got]));
            got++;
         end
         if (in_valid32 && in_ready32) sent++;
      end
      @(negedge clk);
      in_valid32  = 1'b0;
      out_ready32 = 1'b1;
      check("stream:retired", 64'(got), 64'(6));
      check("stream:accepted", 64'(sent), 64'(6));
      repeat (5) begin
         @(negedge clk);
         check("stream:no_dup", 64'(out_valid32), 64'(0));
      end

      // Three operations in flight, then a half-cycle reset pulse
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a32 = 32'(i + 1); b32 = 32'h1; sub32 = 1'b0; cin32 = 1'b0; in_valid32 = 1'b1;
      end
      @(negedge clk);
      in_valid32 = 1'b0;
      @(posedge clk);
      #2;
      check("midrst:pre_valid", 64'(out_valid32), 64'(1));
      rst_n = 1'b0;
      #1;
      check("midrst:out_valid", 64'(out_valid32), 64'(0));
      check("midrst:sum", 64'(sum32), 64'(0));
      check("midrst:in_ready", 64'(in_ready32), 64'(1));
      #4 rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("midrst:lost", 64'(out_valid32), 64'(0));
      end
      run32("post_rst", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);

      // 16-bit instance, four 4-bit blocks
      @(negedge clk);
      a16 = 16'h00FF; b16 = 16'h0001; in_valid16 = 1'b1;
      #1 check("w16:in_ready", 64'(in_ready16), 64'(1));
      @(negedge clk);
      in_valid16 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("w16:valid", 64'(out_valid16), 64'(i == 3));
      end
      check("w16:sum", 64'(sum16), 64'(16'h0100));
      check("w16:cout", 64'(cout16), 64'(0));
      check("w16:ovf", 64'(ovf16), 64'(0));

      // 8-bit instance, single block: result after the accepting edge
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      check("w8:valid", 64'(out_valid8), 64'(1));
      check("w8:sum", 64'(sum8), 64'(8'h00));
      check("w8:cout", 64'(cout8), 64'(1));
      check("w8:ovf", 64'(ovf8), 64'(1));
      @(negedge clk);
      check("w8:retired", 64'(out_valid8), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor for the processor datapath. It splits a WIDTH-bit operation into NBLK = WIDTH/BLOCK carry-select blocks and registers one block per stage, so it accepts one operation per cycle at any width. A valid/ready handshake on each side supports backpressure from the writeback stage. It supports add and subtract, with borrow-in, carry-out and signed-overflow flags.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of BLOCK.
- BLOCK, 8, bits per carry-select block; NBLK = WIDTH/BLOCK ≥ 1; latency = NBLK.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  operation presented.
- in_ready  output  1  stage can accept; an operation transfers on in_valid && in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A − B, 0 = A + B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts; result retires on out_valid && out_ready.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of bit WIDTH−1.
- ovf  output  1  signed two's-complement overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; carry-in c0 = cin ^ sub.
  - sub=0: A+B+cin.
  - sub=1, cin=0: A−B.
  - sub=1, cin=1: A−B−1.
- Block k (bits k·BLOCK+BLOCK−1 : k·BLOCK) is computed in stage k.
  - Stage k forms two candidate sums/carries (carry-in 0 and 1) from its slice.
  - It selects between them using the carry registered by stage k−1 (c0 for k=0).
- Each stage register holds: valid bit, completed low result slices, carry out of the block, and the not-yet-used upper slices of A and B'.
  - Operands are skewed forward so each stage sees only its own slice.
- Last stage also registers:
  - cout = carry out of the top block.
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1 (computed inside the top block).
- Single global stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stall=1, every stage register holds its value and no input is accepted.
  - When stall=0, all stages advance; bubbles (valid=0) propagate as bubbles.
- Ordering is strictly FIFO; no operation is dropped or duplicated.
- sum/cout/ovf are meaningful only while out_valid=1. They hold stable while stalled.

## Timing
- Reset (reset=0, asynchronous): all stage valid bits, out_valid, sum, cout and ovf clear to 0 immediately.
  - Pipeline contents are discarded; in_ready=1 while reset is asserted and afterwards.
- Release of reset is sampled on a rising edge; the first transfer is possible on the first edge with reset=1.
- Latency: an operation accepted at edge t produces out_valid=1 after edge t+NBLK−1 (visible in cycle t+NBLK−1 … for NBLK=1 the result appears after the accepting edge). Equivalently, out_valid rises NBLK edges after the operation is captured into stage 0 from the input, counting the capture edge.
- Throughput: 1 operation/cycle when out_ready=1.
- Backpressure: in_ready falls combinationally in the same cycle as out_valid && !out_ready. It rises the cycle out_ready returns to 1.
- Simultaneous retire and accept (out_ready=1, in_valid=1): both occur on the same edge.
- in_valid=1 while in_ready=0: the input is not captured. The source must hold it.
- Reset mid-stream: in-flight operations are lost; no result for them ever appears.

## Test plan
- WIDTH=32, BLOCK=8, out_ready=1: a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 → sum=0x00000000, cout=1, ovf=0, out_valid high exactly 4 cycles after acceptance.
- a=0x7FFFFFFF, b=0x00000001, add → sum=0x80000000, cout=0, ovf=1. a=0x00000005, b=0x00000007, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0.
- a=0x80000000, b=0x00000001, sub=1, cin=0 → sum=0x7FFFFFFF, cout=1, ovf=1. Same operands with cin=1 → sum=0x7FFFFFFE.
- Six back-to-back operations; drop out_ready for 3 cycles when the first result appears → in_ready=0 in those cycles, sum held stable, all six results emerge in order with none lost or duplicated.
- Three operations in flight; pulse reset low for half a cycle mid-cycle → out_valid=0 immediately, no result emitted after release, and the next accepted operation returns correctly after 4 cycles.
- Instance WIDTH=16, BLOCK=4: a=0x00FF, b=0x0001, add → sum=0x0100, cout=0, latency 4. Instance WIDTH=8, BLOCK=8 (NBLK=1): a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
